// File: rtl/unibus_pkg.sv
// unibus_pkg: shared definitions for the Unibus CPU-side bus arbiter.
//   - arb_state_t : arbiter FSM encoding (idle / grant out / device selected)
//   - GNT_*       : winner index constants (NPR = 4, BR7 = 3 ... BR4 = 0)
//   - br_level()  : maps a BR index 0..3 to its bus priority level 4..7
//   - grant_vec() : decodes a winner index into {npg, bg7, bg6, bg5, bg4}
package unibus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_GRANT    = 2'd1,
    ARB_SELECTED = 2'd2
  } arb_state_t;

  localparam logic [2:0] GNT_NPR = 3'd4;
  localparam logic [2:0] GNT_BR7 = 3'd3;
  localparam logic [2:0] GNT_BR6 = 3'd2;
  localparam logic [2:0] GNT_BR5 = 3'd1;
  localparam logic [2:0] GNT_BR4 = 3'd0;

  // BR index i sits on priority level i + 4 (BR4 = 4 ... BR7 = 7).
  function automatic logic [2:0] br_level(input logic [1:0] idx);
    return {1'b1, idx};
  endfunction

  // Bit 4 is NPG, bits 3..0 are BG7..BG4.
  function automatic logic [4:0] grant_vec(input logic [2:0] idx);
    logic [4:0] v;
    v = 5'b0_0000;
    case (idx)
      GNT_NPR: v = 5'b1_0000;
      GNT_BR7: v = 5'b0_1000;
      GNT_BR6: v = 5'b0_0100;
      GNT_BR5: v = 5'b0_0010;
      GNT_BR4: v = 5'b0_0001;
      default: v = 5'b0_0000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/unibus_arb_pick.sv
// unibus_arb_pick: combinational priority encoder for the Unibus arbiter.
// Priority is NPR > BR7 > BR6 > BR5 > BR4. A BR level is eligible only when
// the CPU is at an instruction boundary and the level beats the PSW priority.
// Ports:
//   bus_npr    in  non-processor request
//   bus_br     in  BR7..BR4 (bit3 = BR7)
//   cpu_prio   in  current PSW priority 0..7
//   cpu_br_ok  in  CPU at instruction boundary
//   pick_valid out at least one eligible request
//   pick_idx   out winner index (GNT_NPR / GNT_BR7..GNT_BR4)
// Parameter NPR_ANYTIME: 1 lets NPR win mid-instruction, 0 gates it like BR.
module unibus_arb_pick
  import unibus_pkg::*;
#(
  parameter bit NPR_ANYTIME = 1'b1
) (
  input  logic       bus_npr,
  input  logic [3:0] bus_br,
  input  logic [2:0] cpu_prio,
  input  logic       cpu_br_ok,
  output logic       pick_valid,
  output logic [2:0] pick_idx
);

  logic npr_ok;

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = GNT_BR4;
    npr_ok     = NPR_ANYTIME ? 1'b1 : cpu_br_ok;

    // Ascending scan: a higher eligible level overwrites a lower one.
    if (cpu_br_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (bus_br[i] && (br_level(2'(i)) > cpu_prio)) begin
          pick_valid = 1'b1;
          pick_idx   = 3'(i);
        end
      end
    end

    // NPR overrides any BR winner.
    if (bus_npr && npr_ok) begin
      pick_valid = 1'b1;
      pick_idx   = GNT_NPR;
    end
  end

endmodule

// File: rtl/unibus_arb.sv
// unibus_arb: CPU-side Unibus bus-request arbiter. Samples NPR and BR7..BR4,
// grants one winner on NPG or BG7..BG4, completes the SACK/BBSY handover and
// returns to idle after a deskew gap.
// Ports:
//   clk         in  system clock
//   reset       in  synchronous active-high reset
//   bus_init    in  Unibus INIT, same effect as reset while high
//   bus_npr     in  non-processor request
//   bus_br      in  BR7..BR4 (bit3 = BR7)
//   bus_sack    in  selection acknowledge from device
//   bus_bbsy    in  bus busy (wired-OR)
//   cpu_prio    in  current PSW priority 0..7
//   cpu_br_ok   in  CPU at instruction boundary
//   bus_npg     out NPR grant
//   bus_bg      out BG7..BG4
//   arb_busy    out arbiter not idle
//   arb_timeout out one-cycle pulse when a grant expires without SACK
//   arb_stats   out (only with UNIBUS_ARB_STATS_EN) {timeouts, completed grants}
// Optional feature macro: UNIBUS_ARB_STATS_EN.
//
// Grant handshake: a grant goes high one cycle after an eligible request is
// seen in IDLE, and stays high until the device raises SACK, the winning
// request line drops, or SACK_TIMEOUT cycles elapse. SACK takes precedence
// over both withdrawal and timeout. After SACK the arbiter waits for SACK and
// BBSY both low before returning to IDLE, where it holds all grants low for
// GRANT_GAP cycles before the next grant.
module unibus_arb
  import unibus_pkg::*;
#(
  parameter int unsigned SACK_TIMEOUT = 'o1000,
  parameter int unsigned GRANT_GAP    = 2,
  parameter bit          NPR_ANYTIME  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_init,
  input  logic        bus_npr,
  input  logic [3:0]  bus_br,
  input  logic        bus_sack,
  input  logic        bus_bbsy,
  input  logic [2:0]  cpu_prio,
  input  logic        cpu_br_ok,
  output logic        bus_npg,
  output logic [3:0]  bus_bg,
  output logic        arb_busy,
  output logic        arb_timeout
`ifdef UNIBUS_ARB_STATS_EN
  ,
  output logic [31:0] arb_stats
`endif
);

  localparam logic [7:0]  GAP_RELOAD   = 8'(GRANT_GAP);
  localparam logic [15:0] TIMEOUT_LAST = 16'(SACK_TIMEOUT - 1);

  arb_state_t  state;
  logic [15:0] timer;
  logic [7:0]  gap_cnt;
  logic [2:0]  win_idx;

  logic        pick_valid;
  logic [2:0]  pick_idx;
  logic        win_req;
  logic        enter_selected;
  logic        timeout_hit;
  logic        init_any;

  unibus_arb_pick #(
    .NPR_ANYTIME(NPR_ANYTIME)
  ) u_pick (
    .bus_npr   (bus_npr),
    .bus_br    (bus_br),
    .cpu_prio  (cpu_prio),
    .cpu_br_ok (cpu_br_ok),
    .pick_valid(pick_valid),
    .pick_idx  (pick_idx)
  );

  assign init_any = reset | bus_init;

  // The latched winner's own request line; cpu_prio and cpu_br_ok are not
  // rechecked, so a granted request keeps its grant if the PSW rises.
  assign win_req = (win_idx == GNT_NPR) ? bus_npr : bus_br[win_idx[1:0]];

  assign enter_selected = (state == ARB_GRANT) && bus_sack;
  assign timeout_hit    = (state == ARB_GRANT) && !bus_sack && win_req &&
                          (timer == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (init_any) begin
      state       <= ARB_IDLE;
      bus_npg     <= 1'b0;
      bus_bg      <= 4'b0000;
      arb_busy    <= 1'b0;
      arb_timeout <= 1'b0;
      timer       <= 16'd0;
      gap_cnt     <= GAP_RELOAD;
      win_idx     <= GNT_BR4;
    end else begin
      arb_timeout <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (gap_cnt != 8'd0) begin
            gap_cnt <= gap_cnt - 8'd1;
          end else if (!bus_sack && pick_valid) begin
            // A SACK still high here is stale and blocks new grants.
            win_idx            <= pick_idx;
            {bus_npg, bus_bg}  <= grant_vec(pick_idx);
            timer              <= 16'd0;
            arb_busy           <= 1'b1;
            state              <= ARB_GRANT;
          end
        end

        ARB_GRANT: begin
          if (timer != 16'hFFFF) begin
            timer <= timer + 16'd1;
          end
          if (bus_sack) begin
            bus_npg <= 1'b0;
            bus_bg  <= 4'b0000;
            state   <= ARB_SELECTED;
          end else if (!win_req) begin
            bus_npg  <= 1'b0;
            bus_bg   <= 4'b0000;
            arb_busy <= 1'b0;
            gap_cnt  <= GAP_RELOAD;
            state    <= ARB_IDLE;
          end else if (timer == TIMEOUT_LAST) begin
            bus_npg     <= 1'b0;
            bus_bg      <= 4'b0000;
            arb_busy    <= 1'b0;
            arb_timeout <= 1'b1;
            gap_cnt     <= GAP_RELOAD;
            state       <= ARB_IDLE;
          end
        end

        ARB_SELECTED: begin
          // Device owns the bus; wait for it to release both SACK and BBSY.
          if (!bus_sack && !bus_bbsy) begin
            arb_busy <= 1'b0;
            gap_cnt  <= GAP_RELOAD;
            state    <= ARB_IDLE;
          end
        end

        default: begin
          bus_npg  <= 1'b0;
          bus_bg   <= 4'b0000;
          arb_busy <= 1'b0;
          gap_cnt  <= GAP_RELOAD;
          state    <= ARB_IDLE;
        end
      endcase
    end
  end

`ifdef UNIBUS_ARB_STATS_EN
  logic [15:0] grant_cnt;
  logic [15:0] timeout_cnt;

  always_ff @(posedge clk) begin
    if (init_any) begin
      grant_cnt   <= 16'd0;
      timeout_cnt <= 16'd0;
    end else begin
      if (enter_selected) begin
        grant_cnt <= grant_cnt + 16'd1;
      end
      if (timeout_hit) begin
        timeout_cnt <= timeout_cnt + 16'd1;
      end
    end
  end

  assign arb_stats = {timeout_cnt, grant_cnt};
`else
  // Without the statistics block these event strobes have no consumer.
  logic unused_events;
  assign unused_events = enter_selected ^ timeout_hit;
`endif

endmodule

// File: tb/tb_unibus_arb.sv
// tb_unibus_arb: directed bench for unibus_arb. Two instances share stimulus:
// dut (NPR_ANYTIME = 1) and dut_n (NPR_ANYTIME = 0).
module tb_unibus_arb;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset     = 1'b1;
  logic       bus_init  = 1'b0;
  logic       bus_npr   = 1'b0;
  logic [3:0] bus_br    = 4'b0000;
  logic       bus_sack  = 1'b0;
  logic       bus_bbsy  = 1'b0;
  logic [2:0] cpu_prio  = 3'd7;
  logic       cpu_br_ok = 1'b1;

  logic       bus_npg,   bus_npg_n;
  logic [3:0] bus_bg,    bus_bg_n;
  logic       arb_busy,  arb_busy_n;
  logic       arb_timeout, arb_timeout_n;
`ifdef UNIBUS_ARB_STATS_EN
  logic [31:0] arb_stats, arb_stats_n;
`endif

  unibus_arb dut (
    .clk        (clk),
    .reset      (reset),
    .bus_init   (bus_init),
    .bus_npr    (bus_npr),
    .bus_br     (bus_br),
    .bus_sack   (bus_sack),
    .bus_bbsy   (bus_bbsy),
    .cpu_prio   (cpu_prio),
    .cpu_br_ok  (cpu_br_ok),
    .bus_npg    (bus_npg),
    .bus_bg     (bus_bg),
    .arb_busy   (arb_busy),
    .arb_timeout(arb_timeout)
`ifdef UNIBUS_ARB_STATS_EN
    ,
    .arb_stats  (arb_stats)
`endif
  );

  unibus_arb #(.NPR_ANYTIME(1'b0)) dut_n (
    .clk        (clk),
    .reset      (reset),
    .bus_init   (bus_init),
    .bus_npr    (bus_npr),
    .bus_br     (bus_br),
    .bus_sack   (bus_sack),
    .bus_bbsy   (bus_bbsy),
    .cpu_prio   (cpu_prio),
    .cpu_br_ok  (cpu_br_ok),
    .bus_npg    (bus_npg_n),
    .bus_bg     (bus_bg_n),
    .arb_busy   (arb_busy_n),
    .arb_timeout(arb_timeout_n)
`ifdef UNIBUS_ARB_STATS_EN
    ,
    .arb_stats  (arb_stats_n)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  int to_cnt  = 0;
  logic [4:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // At most one grant line per instance, every cycle; count timeout pulses.
  always @(negedge clk) begin
    if (!$onehot0({bus_npg, bus_bg}) || !$onehot0({bus_npg_n, bus_bg_n})) begin
      n_total++;
      $error("FAIL onehot_grant: observed %b/%b expected at most one high",
             {bus_npg, bus_bg}, {bus_npg_n, bus_bg_n});
    end
    if (arb_timeout === 1'b1) to_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int to_base;
    logic held_ok;

    // Reset state
    reset = 1'b1;
    tick_n(2);
    check("rst_npg", bus_npg, 1'b0);
    check("rst_bg", bus_bg, 4'b0000);
    check("rst_busy", arb_busy, 1'b0);
    check("rst_timeout", arb_timeout, 1'b0);
    reset = 1'b0;

    // T1: BR6 above prio 5; gap holds off the first grant for two cycles
    bus_br = 4'b0100; cpu_prio = 3'd5;
    tick_n(2);
    check("t1_gap_after_reset", bus_bg, 4'b0000);
    tick();
    check("t1_bg6", bus_bg, 4'b0100);
    check("t1_busy", arb_busy, 1'b1);
    tick_n(2);
    check("t1_bg6_held", bus_bg, 4'b0100);
    bus_sack = 1'b1; bus_bbsy = 1'b1; bus_br = 4'b0000;
    tick();
    check("t1_sack_drop", bus_bg, 4'b0000);
    check("t1_selected_busy", arb_busy, 1'b1);
    bus_sack = 1'b0;
    tick();
    check("t1_bbsy_hold", arb_busy, 1'b1);
    bus_bbsy = 1'b0;
    tick();
    check("t1_idle", arb_busy, 1'b0);
    bus_br = 4'b0100;
    tick_n(2);
    check("t1_regrant_gap", bus_bg, 4'b0000);
    tick();
    check("t1_regrant", bus_bg, 4'b0100);
    bus_sack = 1'b1;
    tick();
    bus_sack = 1'b0; bus_br = 4'b0000;
    tick();
    check("t1_done", arb_busy, 1'b0);

    // T2: NPR and BR7 together; NPR first, then BR7
    exp_q.push_back(5'b1_0000);
    exp_q.push_back(5'b0_1000);
    bus_npr = 1'b1; bus_br = 4'b1000; cpu_prio = 3'd0;
    tick_n(3);
    check("t2_first", {bus_npg, bus_bg}, exp_q.pop_front());
    // SACK and withdrawal in the same cycle: SACK wins
    bus_sack = 1'b1; bus_bbsy = 1'b1; bus_npr = 1'b0;
    tick();
    check("t2_sack_wins", arb_busy, 1'b1);
    check("t2_npg_low", bus_npg, 1'b0);
    bus_sack = 1'b0; bus_bbsy = 1'b0;
    tick();
    check("t2_idle", arb_busy, 1'b0);
    tick_n(2);
    check("t2_gap", bus_bg, 4'b0000);
    tick();
    check("t2_second", {bus_npg, bus_bg}, exp_q.pop_front());
    bus_sack = 1'b1; bus_br = 4'b0000;
    tick();
    bus_sack = 1'b0;
    tick();

    // T3: BR5 at prio 5 never granted; prio 4 grants; prio rise keeps grant
    bus_br = 4'b0010; cpu_prio = 3'd5;
    tick_n(6);
    check("t3_blocked_bg", bus_bg, 4'b0000);
    check("t3_blocked_busy", arb_busy, 1'b0);
    cpu_prio = 3'd4;
    tick();
    check("t3_bg5", bus_bg, 4'b0010);
    cpu_prio = 3'd7;
    tick();
    check("t3_prio_rise_held", bus_bg, 4'b0010);
    to_base = to_cnt;
    bus_br = 4'b0000;
    tick();
    check("t3_withdraw_bg", bus_bg, 4'b0000);
    check("t3_withdraw_busy", arb_busy, 1'b0);
    check("t3_withdraw_no_to", arb_timeout, 1'b0);

    // T4: BR4 with no SACK times out after 512 granted cycles
    bus_br = 4'b0001; cpu_prio = 3'd0;
    tick_n(3);
    check("t4_bg4", bus_bg, 4'b0001);
    held_ok = 1'b1;
    for (int i = 1; i < 512; i++) begin
      tick();
      if (bus_bg !== 4'b0001 || arb_timeout !== 1'b0) held_ok = 1'b0;
    end
    check("t4_held_511", held_ok, 1'b1);
    tick();
    check("t4_to_bg", bus_bg, 4'b0000);
    check("t4_to_pulse", arb_timeout, 1'b1);
    check("t4_to_busy", arb_busy, 1'b0);
    bus_br = 4'b0000;
    tick();
    check("t4_pulse_end", arb_timeout, 1'b0);
    check("t4_pulse_count", to_cnt - to_base, 1);
`ifdef UNIBUS_ARB_STATS_EN
    check("t4_stats_to", arb_stats[31:16], 16'd1);
`endif

    // T4b: SACK arriving on the timeout cycle wins, no pulse
    bus_br = 4'b0001;
    tick_n(2);
    check("t4b_bg4", bus_bg, 4'b0001);
    tick_n(511);
    bus_sack = 1'b1; bus_bbsy = 1'b1;
    tick();
    check("t4b_bg_low", bus_bg, 4'b0000);
    check("t4b_no_pulse", arb_timeout, 1'b0);
    check("t4b_selected", arb_busy, 1'b1);
    bus_sack = 1'b0; bus_bbsy = 1'b0; bus_br = 4'b0000;
    tick();
    check("t4b_idle", arb_busy, 1'b0);
    check("t4b_pulse_count", to_cnt - to_base, 1);
`ifdef UNIBUS_ARB_STATS_EN
    check("t4b_stats", arb_stats, {16'd1, 16'd5});
`endif

    // T5: reset and bus_init while in GRANT
    bus_br = 4'b1000;
    tick_n(3);
    check("t5_bg7", bus_bg, 4'b1000);
    reset = 1'b1;
    tick();
    check("t5_rst_bg", bus_bg, 4'b0000);
    check("t5_rst_busy", arb_busy, 1'b0);
    reset = 1'b0;
    tick_n(2);
    check("t5_rst_gap", bus_bg, 4'b0000);
    tick();
    check("t5_rst_regrant", bus_bg, 4'b1000);
    bus_init = 1'b1;
    tick();
    check("t5_init_bg", bus_bg, 4'b0000);
    check("t5_init_busy", arb_busy, 1'b0);
    bus_init = 1'b0;
    tick_n(2);
    check("t5_init_gap", bus_bg, 4'b0000);
    tick();
    check("t5_init_regrant", bus_bg, 4'b1000);
    bus_br = 4'b0000;
    tick();

    // T6: NPR_ANYTIME = 0 waits for cpu_br_ok
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cpu_br_ok = 1'b0; bus_npr = 1'b1; cpu_prio = 3'd7;
    tick_n(3);
    check("t6_anytime_npg", bus_npg, 1'b1);
    check("t6_gated_npg", bus_npg_n, 1'b0);
    tick_n(2);
    check("t6_gated_still", bus_npg_n, 1'b0);
    cpu_br_ok = 1'b1;
    tick();
    check("t6_npg_after_ok", bus_npg_n, 1'b1);
    bus_npr = 1'b0;
    tick();
    check("t6_withdraw_npg", bus_npg_n, 1'b0);
    check("t6_withdraw_busy", arb_busy_n, 1'b0);
    check("t6_withdraw_no_to", arb_timeout_n, 1'b0);

    // T7: stale SACK in IDLE blocks grants until it drops
    bus_sack = 1'b1; bus_br = 4'b1000; cpu_prio = 3'd0;
    tick_n(4);
    check("t7_stale_bg", bus_bg, 4'b0000);
    check("t7_stale_busy", arb_busy, 1'b0);
    bus_sack = 1'b0;
    tick();
    check("t7_grant", bus_bg, 4'b1000);
    check("t7_grant_n", bus_bg_n, 4'b1000);
    bus_br = 4'b0000;
    tick();
    check("t7_done", arb_busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
